// File: rtl/smg_bin2bcd_module.sv
// Sequential shift-add-3 binary-to-BCD converter feeding the SMG scan controller.
// One iteration per clock; the result register only updates on completion, so the display never shows a partial value.
module smg_bin2bcd_module #(
    parameter int unsigned BIN_W  = 20,
    parameter int unsigned DIGITS = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  Start_Sig,
    input  logic [BIN_W-1:0]      Bin_Data,
    output logic                  Busy_Sig,
    output logic                  Done_Sig,
    output logic                  Overflow_Sig,
    output logic [4*DIGITS-1:0]   Number_Sig
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(BIN_W);

    localparam logic [BIN_W-1:0] MAX_VAL   = BIN_W'(10 ** DIGITS - 1);
    localparam logic [BCD_W-1:0] ALL_NINES = {DIGITS{4'h9}};
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [BIN_W-1:0] bin_q, bin_nxt;
    logic [BCD_W-1:0] bcd_q, bcd_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic             ovf_q, ovf_nxt;

    logic [BCD_W-1:0] number_nxt;
    logic             overflow_nxt;
    logic             busy_nxt;
    logic             done_nxt;
    logic [BCD_W-1:0] bcd_adj;

    // Per-nibble +3 correction; nibbles are independent, no carry between them.
    function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        r = v;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (v[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = v[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (Start_Sig) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q == LAST_ITER) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath and output next values; everything holds unless the state says otherwise.
    always_comb begin
        bin_nxt      = bin_q;
        bcd_nxt      = bcd_q;
        cnt_nxt      = cnt_q;
        ovf_nxt      = ovf_q;
        number_nxt   = Number_Sig;
        overflow_nxt = Overflow_Sig;
        busy_nxt     = Busy_Sig;
        done_nxt     = 1'b0;
        bcd_adj      = add3(bcd_q);
        case (state)
            IDLE: begin
                if (Start_Sig) begin
                    bin_nxt  = Bin_Data;
                    bcd_nxt  = '0;
                    cnt_nxt  = '0;
                    ovf_nxt  = (Bin_Data > MAX_VAL);
                    busy_nxt = 1'b1;
                end
            end
            SHIFT: begin
                {bcd_nxt, bin_nxt} = {bcd_adj, bin_q} << 1;
                cnt_nxt            = cnt_q + CNT_W'(1);
            end
            DONE: begin
                // Out-of-range inputs saturate to all nines rather than showing a wrapped value.
                number_nxt   = ovf_q ? ALL_NINES : bcd_q;
                overflow_nxt = ovf_q;
                done_nxt     = 1'b1;
                busy_nxt     = 1'b0;
            end
            default: begin
                busy_nxt = 1'b0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            bin_q        <= '0;
            bcd_q        <= '0;
            cnt_q        <= '0;
            ovf_q        <= 1'b0;
            Number_Sig   <= '0;
            Overflow_Sig <= 1'b0;
            Busy_Sig     <= 1'b0;
            Done_Sig     <= 1'b0;
        end else begin
            bin_q        <= bin_nxt;
            bcd_q        <= bcd_nxt;
            cnt_q        <= cnt_nxt;
            ovf_q        <= ovf_nxt;
            Number_Sig   <= number_nxt;
            Overflow_Sig <= overflow_nxt;
            Busy_Sig     <= busy_nxt;
            Done_Sig     <= done_nxt;
        end
    end

endmodule

// File: tb/tb_smg_bin2bcd_module.sv
// Directed and table-driven bench for smg_bin2bcd_module.
// Expected values come from hand-written tables and a divide-by-ten reference model.
module tb_smg_bin2bcd_module;

    logic        CLK;
    logic        RST;
    logic        Start_Sig;
    logic [19:0] Bin_Data;
    logic        Busy_Sig;
    logic        Done_Sig;
    logic        Overflow_Sig;
    logic [23:0] Number_Sig;

    int total;
    int bad;

    typedef struct {
        logic [19:0] bin;
        logic [23:0] num;
        logic        ovf;
    } vec_t;

    vec_t vecs[12];

    smg_bin2bcd_module dut (
        .CLK          (CLK),
        .RST          (RST),
        .Start_Sig    (Start_Sig),
        .Bin_Data     (Bin_Data),
        .Busy_Sig     (Busy_Sig),
        .Done_Sig     (Done_Sig),
        .Overflow_Sig (Overflow_Sig),
        .Number_Sig   (Number_Sig)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] bcd_ref(input int unsigned v);
        logic [23:0]  r;
        int unsigned  t;
        r = '0;
        if (v > 999999) return 24'h999999;
        t = v;
        for (int i = 0; i < 6; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // One conversion by a start pulse; glitch>0 re-pulses Start with Bin_Data=42 at that cycle.
    task automatic run_conv(input logic [19:0] v, input logic [23:0] exp_n,
                            input logic exp_o, input int glitch, input string tag);
        logic [23:0] prev;
        logic        busy_ok, hold_ok, seen;
        int          cyc;
        @(negedge CLK);
        prev      = Number_Sig;
        Start_Sig = 1'b1;
        Bin_Data  = v;
        @(posedge CLK);
        #1;
        Start_Sig = 1'b0;
        Bin_Data  = ~v;
        busy_ok   = Busy_Sig;
        hold_ok   = 1'b1;
        seen      = 1'b0;
        cyc       = 0;
        while (!seen && cyc < 40) begin
            @(posedge CLK);
            cyc++;
            #1;
            if (cyc == glitch) begin
                Start_Sig = 1'b1;
                Bin_Data  = 20'd42;
            end else begin
                Start_Sig = 1'b0;
            end
            if (Done_Sig) begin
                seen = 1'b1;
            end else begin
                if (!Busy_Sig) busy_ok = 1'b0;
                if (Number_Sig !== prev) hold_ok = 1'b0;
            end
        end
        Start_Sig = 1'b0;
        check({tag, " latency"}, 32'(cyc), 32'd21);
        check({tag, " busy_during"}, 32'(busy_ok), 32'd1);
        check({tag, " number_held"}, 32'(hold_ok), 32'd1);
        check({tag, " number"}, 32'(Number_Sig), 32'(exp_n));
        check({tag, " overflow"}, 32'(Overflow_Sig), 32'(exp_o));
        check({tag, " busy_at_done"}, 32'(Busy_Sig), 32'd0);
        @(posedge CLK);
        #1;
        check({tag, " done_one_cycle"}, 32'(Done_Sig), 32'd0);
    endtask

    int          dones;
    int          last_done;
    int          c;
    logic [19:0] hist[160];
    logic [19:0] rv;

    initial begin
        total     = 0;
        bad       = 0;
        RST       = 1'b1;
        Start_Sig = 1'b0;
        Bin_Data  = '0;

        vecs[0]  = '{20'd0,       24'h000000, 1'b0};
        vecs[1]  = '{20'd123456,  24'h123456, 1'b0};
        vecs[2]  = '{20'd999999,  24'h999999, 1'b0};
        vecs[3]  = '{20'd1048575, 24'h999999, 1'b1};
        vecs[4]  = '{20'd1000000, 24'h999999, 1'b1};
        vecs[5]  = '{20'd1,       24'h000001, 1'b0};
        vecs[6]  = '{20'd9,       24'h000009, 1'b0};
        vecs[7]  = '{20'd10,      24'h000010, 1'b0};
        vecs[8]  = '{20'd65535,   24'h065535, 1'b0};
        vecs[9]  = '{20'd500000,  24'h500000, 1'b0};
        vecs[10] = '{20'd100000,  24'h100000, 1'b0};
        vecs[11] = '{20'd999998,  24'h999998, 1'b0};

        // Reset state
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        check("rst number", 32'(Number_Sig), 32'd0);
        check("rst busy", 32'(Busy_Sig), 32'd0);
        check("rst done", 32'(Done_Sig), 32'd0);
        check("rst ovf", 32'(Overflow_Sig), 32'd0);

        for (int i = 0; i < 12; i++) begin
            run_conv(vecs[i].bin, vecs[i].num, vecs[i].ovf, -1, $sformatf("vec%0d", i));
        end

        // Restart attempt while busy must be ignored and not queued
        run_conv(20'd654321, 24'h654321, 1'b0, 5, "restart");
        dones = 0;
        repeat (25) begin
            @(posedge CLK);
            #1;
            if (Done_Sig) dones++;
        end
        check("restart no_queue", 32'(dones), 32'd0);

        // Reset mid-conversion aborts it without a Done
        @(negedge CLK);
        Start_Sig = 1'b1;
        Bin_Data  = 20'd777;
        @(posedge CLK);
        #1;
        Start_Sig = 1'b0;
        repeat (9) @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        check("abort busy", 32'(Busy_Sig), 32'd0);
        check("abort number", 32'(Number_Sig), 32'd0);
        check("abort ovf", 32'(Overflow_Sig), 32'd0);
        dones = 0;
        repeat (30) begin
            @(posedge CLK);
            #1;
            if (Done_Sig) dones++;
        end
        check("abort no_done", 32'(dones), 32'd0);
        run_conv(20'd90, 24'h000090, 1'b0, -1, "after_abort");

        // Start held high: back-to-back conversions every 22 cycles
        @(negedge CLK);
        Start_Sig = 1'b1;
        Bin_Data  = 20'd0;
        dones     = 0;
        last_done = -1;
        c         = 0;
        while (dones < 3 && c < 150) begin
            @(posedge CLK);
            hist[c] = Bin_Data;
            #1;
            if (Done_Sig) begin
                if (last_done < 0) begin
                    check("held first_latency", 32'(c), 32'd21);
                end else begin
                    check("held period", 32'(c - last_done), 32'd22);
                end
                if (c >= 21) begin
                    check("held number", 32'(Number_Sig), 32'(bcd_ref(32'(hist[c-21]))));
                end
                last_done = c;
                dones++;
                if (dones == 3) Start_Sig = 1'b0;
            end
            Bin_Data = (Bin_Data == 20'd50) ? 20'd0 : Bin_Data + 20'd1;
            c++;
        end
        Start_Sig = 1'b0;
        check("held done_count", 32'(dones), 32'd3);
        repeat (25) @(posedge CLK);

        // Random sweep against the reference model
        for (int i = 0; i < 6; i++) begin
            rv = 20'($urandom_range(0, 1048575));
            run_conv(rv, bcd_ref(32'(rv)), (rv > 20'd999999), -1, $sformatf("rand%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
